// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - synchronise and debounce board inputs, with edge pulses and sticky change mask
module gpio_input_conditioner #(
    parameter int               WIDTH          = 16,
    parameter int               SYNC_STAGES    = 2,
    parameter int               TICK_DIV       = 50000,
    parameter int               DEBOUNCE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] clean_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] change_mask_o,
    output logic             change_o,
    input  logic             change_ack_i
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DCNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic             tick;
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CW-1:0]    dcnt_q [WIDTH];
    logic [CW-1:0]    dcnt_d [WIDTH];
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             change_q, change_d;

    // Only the last synchroniser stage is ever looked at by the debounce logic.
    assign s = sync_q[SYNC_STAGES-1];

    // Shift raw pins through the synchroniser chain.
    always_comb begin
        sync_d[0] = raw_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Shared sample-tick prescaler; tick fires on the last count before wrap.
    always_comb begin
        tick  = (cnt_q == TICK_LAST);
        cnt_d = tick ? '0 : cnt_q + PW'(1);
    end

    // Per-channel debounce FSM; a mismatch going away always wins over a tick.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        clean_d = clean_q;
        for (int i = 0; i < WIDTH; i++) begin
            case (state_q[i])
                STABLE: begin
                    if (s[i] != clean_q[i]) begin
                        state_d[i] = SETTLING;
                        dcnt_d[i]  = '0;
                    end
                end
                SETTLING: begin
                    if (s[i] == clean_q[i]) begin
                        state_d[i] = STABLE;
                        dcnt_d[i]  = '0;
                    end else if (tick) begin
                        if (dcnt_q[i] == DCNT_LAST) begin
                            clean_d[i] = s[i];
                            state_d[i] = STABLE;
                            dcnt_d[i]  = '0;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = STABLE;
                    dcnt_d[i]  = '0;
                end
            endcase
        end
    end

    // Edge pulses line up with the new clean level; ack keeps only brand-new changes.
    always_comb begin
        rise_d   = clean_d & ~clean_q;
        fall_d   = ~clean_d & clean_q;
        mask_d   = change_ack_i ? (rise_d | fall_d) : (mask_q | rise_d | fall_d);
        change_d = |mask_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE;
                dcnt_q[i]  <= '0;
            end
            cnt_q    <= '0;
            clean_q  <= RESET_VALUE;
            rise_q   <= '0;
            fall_q   <= '0;
            mask_q   <= '0;
            change_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            mask_q   <= mask_d;
            change_q <= change_d;
        end
    end

    assign clean_o       = clean_q;
    assign rise_o        = rise_q;
    assign fall_o        = fall_q;
    assign change_mask_o = mask_q;
    assign change_o      = change_q;

endmodule
